// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibits the bus, issues a request-to-send,
// shifts data/parity/stop on device clock falling edges and checks the device ACK.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 750000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       send_valid,
   input  logic [7:0] send_data,
   output logic       send_ready,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe,
   output logic       busy,
   output logic       done,
   output logic       error
);

   localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
   localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      INHIBIT   = 3'd1,
      REQUEST   = 3'd2,
      SEND      = 3'd3,
      ACK       = 3'd4,
      WAIT_IDLE = 3'd5
   } state_t;

   function automatic logic odd_parity(input logic [7:0] b);
      return ~^b;
   endfunction

   state_t        state_q, state_d;
   logic [7:0]    data_q, data_d;
   logic          par_q, par_d;
   logic [3:0]    idx_q, idx_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          clk_oe_q, clk_oe_d;
   logic          dat_oe_q, dat_oe_d;
   logic          ready_q, ready_d;
   logic          done_q, done_d;
   logic          error_q, error_d;
   logic          clk_s1_q, clk_s2_q, clk_prev_q;
   logic          dat_s1_q, dat_s2_q;
   logic          fall_s;

   assign fall_s     = clk_prev_q & ~clk_s2_q;
   assign send_ready = ready_q;
   assign busy       = ~ready_q;
   assign ps2_clk_oe = clk_oe_q;
   assign ps2_dat_oe = dat_oe_q;
   assign done       = done_q;
   assign error      = error_q;

   // Synchronizers reset to the idle-high bus level so reset release is not seen as an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_s1_q   <= 1'b1;
         clk_s2_q   <= 1'b1;
         clk_prev_q <= 1'b1;
         dat_s1_q   <= 1'b1;
         dat_s2_q   <= 1'b1;
      end else begin
         clk_s1_q   <= ps2_clk_in;
         clk_s2_q   <= clk_s1_q;
         clk_prev_q <= clk_s2_q;
         dat_s1_q   <= ps2_dat_in;
         dat_s2_q   <= dat_s1_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         data_q   <= 8'h00;
         par_q    <= 1'b0;
         idx_q    <= 4'd0;
         cnt_q    <= '0;
         clk_oe_q <= 1'b0;
         dat_oe_q <= 1'b0;
         ready_q  <= 1'b1;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         data_q   <= data_d;
         par_q    <= par_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         clk_oe_q <= clk_oe_d;
         dat_oe_q <= dat_oe_d;
         ready_q  <= ready_d;
         done_q   <= done_d;
         error_q  <= error_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      data_d   = data_q;
      par_d    = par_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q + CW'(1);
      clk_oe_d = clk_oe_q;
      dat_oe_d = dat_oe_q;
      ready_d  = ready_q;
      done_d   = 1'b0;
      error_d  = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d    = '0;
            idx_d    = 4'd0;
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            ready_d  = 1'b1;
            if (send_valid && ready_q) begin
               data_d   = send_data;
               par_d    = odd_parity(send_data);
               clk_oe_d = 1'b1;
               ready_d  = 1'b0;
               state_d  = INHIBIT;
            end else begin
               state_d  = IDLE;
            end
         end
         INHIBIT: begin
            if (cnt_q == INH_LAST) begin
               dat_oe_d = 1'b1;
               cnt_d    = '0;
               state_d  = REQUEST;
            end else begin
               state_d  = INHIBIT;
            end
         end
         REQUEST: begin
            clk_oe_d = 1'b0;
            idx_d    = 4'd0;
            cnt_d    = '0;
            state_d  = SEND;
         end
         SEND: begin
            if (fall_s) begin
               cnt_d = '0;
               if (idx_q < 4'd8) begin
                  dat_oe_d = ~data_q[idx_q[2:0]];
                  idx_d    = idx_q + 4'd1;
               end else if (idx_q == 4'd8) begin
                  dat_oe_d = ~par_q;
                  idx_d    = 4'd9;
               end else begin
                  dat_oe_d = 1'b0;
                  state_d  = ACK;
               end
            end else if (cnt_q == TO_LAST) begin
               clk_oe_d = 1'b0;
               dat_oe_d = 1'b0;
               error_d  = 1'b1;
               ready_d  = 1'b1;
               cnt_d    = '0;
               state_d  = IDLE;
            end else begin
               state_d  = SEND;
            end
         end
         ACK: begin
            // The device pulls data low on this edge to acknowledge; high means NACK.
            if (fall_s && !dat_s2_q) begin
               cnt_d   = '0;
               state_d = WAIT_IDLE;
            end else if (fall_s || (cnt_q == TO_LAST)) begin
               clk_oe_d = 1'b0;
               dat_oe_d = 1'b0;
               error_d  = 1'b1;
               ready_d  = 1'b1;
               cnt_d    = '0;
               state_d  = IDLE;
            end else begin
               state_d  = ACK;
            end
         end
         WAIT_IDLE: begin
            if (clk_s2_q && dat_s2_q) begin
               done_d  = 1'b1;
               ready_d = 1'b1;
               cnt_d   = '0;
               state_d = IDLE;
            end else if (cnt_q == TO_LAST) begin
               clk_oe_d = 1'b0;
               dat_oe_d = 1'b0;
               error_d  = 1'b1;
               ready_d  = 1'b1;
               cnt_d    = '0;
               state_d  = IDLE;
            end else begin
               state_d = WAIT_IDLE;
            end
         end
         default: begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            ready_d  = 1'b1;
            cnt_d    = '0;
            state_d  = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a simple PS/2 device model clocks bits out, ACKs/NACKs
// or goes silent, with hand-computed expected ps2_dat_oe sequences.
module tb_ps2_host_tx;

   localparam int INH = 8;
   localparam int TO  = 100;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       send_valid;
   logic [7:0] send_data;
   logic       send_ready;
   logic       ps2_clk_in;
   logic       ps2_dat_in;
   logic       ps2_clk_oe;
   logic       ps2_dat_oe;
   logic       busy;
   logic       done;
   logic       error;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   int both_cnt = 0;

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n), .send_valid(send_valid), .send_data(send_data),
      .send_ready(send_ready), .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in),
      .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe), .busy(busy),
      .done(done), .error(error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (done === 1'b1) done_cnt <= done_cnt + 1;
      if (error === 1'b1) err_cnt <= err_cnt + 1;
      if (done === 1'b1 && error === 1'b1) both_cnt <= both_cnt + 1;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic start_send(input logic [7:0] b);
      @(negedge clk);
      send_valid = 1'b1;
      send_data  = b;
      @(negedge clk);
      send_valid = 1'b0;
      checks++;
      if (busy !== 1'b1 || send_ready !== 1'b0) begin
         errors++;
         $display("FAIL accept %h: busy=%b ready=%b, expected busy=1 ready=0", b, busy, send_ready);
      end
   endtask

   task automatic wait_send_state();
      int n = 0;
      while (!(ps2_clk_oe === 1'b0 && ps2_dat_oe === 1'b1) && n < 50) begin
         n++;
         @(negedge clk);
      end
      checks++;
      if (n >= 50) begin
         errors++;
         $display("FAIL reach_send: clk_oe=%b dat_oe=%b, expected 0/1 within 50 cycles", ps2_clk_oe, ps2_dat_oe);
      end
   endtask

   task automatic clock_bits(input int n, output logic [9:0] got);
      got = '0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         ps2_clk_in = 1'b0;
         tick(5);
         got[i] = ps2_dat_oe;
         ps2_clk_in = 1'b1;
         tick(5);
      end
   endtask

   task automatic run_transfer(input string name, input logic [9:0] exp_bits, input logic ack_val);
      int n;
      int d0;
      int e0;
      logic [9:0] got;
      n = 0;
      while (!(ps2_clk_oe === 1'b1 && ps2_dat_oe === 1'b0) && n < 20) begin
         n++;
         @(negedge clk);
      end
      n = 0;
      while (ps2_clk_oe === 1'b1 && ps2_dat_oe === 1'b0 && n < 100) begin
         n++;
         @(negedge clk);
      end
      checks++;
      if (n != INH) begin
         errors++;
         $display("FAIL %s inhibit_len: got %0d cycles, expected %0d", name, n, INH);
      end
      checks++;
      if (ps2_clk_oe !== 1'b1 || ps2_dat_oe !== 1'b1) begin
         errors++;
         $display("FAIL %s request: clk_oe=%b dat_oe=%b, expected 1/1", name, ps2_clk_oe, ps2_dat_oe);
      end
      @(negedge clk);
      checks++;
      if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b1) begin
         errors++;
         $display("FAIL %s start_bit: clk_oe=%b dat_oe=%b, expected 0/1", name, ps2_clk_oe, ps2_dat_oe);
      end
      clock_bits(10, got);
      checks++;
      if (got !== exp_bits) begin
         errors++;
         $display("FAIL %s bits: got %b, expected %b", name, got, exp_bits);
      end
      d0 = done_cnt;
      e0 = err_cnt;
      ps2_dat_in = ack_val;
      @(negedge clk);
      ps2_clk_in = 1'b0;
      tick(5);
      ps2_clk_in = 1'b1;
      ps2_dat_in = 1'b1;
      n = 0;
      while (send_ready !== 1'b1 && n < 300) begin
         n++;
         @(negedge clk);
      end
      checks++;
      if (n >= 300 || ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0) begin
         errors++;
         $display("FAIL %s end_idle: waited %0d ready=%b clk_oe=%b dat_oe=%b, expected ready=1 oe=0/0",
                  name, n, send_ready, ps2_clk_oe, ps2_dat_oe);
      end
      #1;
      checks++;
      if ((done_cnt - d0) != (ack_val ? 0 : 1) || (err_cnt - e0) != (ack_val ? 1 : 0)) begin
         errors++;
         $display("FAIL %s pulses: done=%0d error=%0d, expected done=%0d error=%0d",
                  name, done_cnt - d0, err_cnt - e0, ack_val ? 0 : 1, ack_val ? 1 : 0);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      send_valid = 1'b0;
      send_data = 8'h00;
      ps2_clk_in = 1'b1;
      ps2_dat_in = 1'b1;
      #3 rst_n = 1'b0;
      #2;
      checks++;
      if (send_ready !== 1'b1 || busy !== 1'b0 || ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0 ||
          done !== 1'b0 || error !== 1'b0) begin
         errors++;
         $display("FAIL reset: ready=%b busy=%b clk_oe=%b dat_oe=%b done=%b error=%b, expected 1 0 0 0 0 0",
                  send_ready, busy, ps2_clk_oe, ps2_dat_oe, done, error);
      end
      tick(3);
      rst_n = 1'b1;
      tick(3);
   endtask

   task automatic test_send_ed();
      start_send(8'hED);
      run_transfer("send_ED", 10'h012, 1'b0);
   endtask

   task automatic test_send_zero();
      start_send(8'h00);
      run_transfer("send_00", 10'h0FF, 1'b0);
   endtask

   task automatic test_nack();
      start_send(8'h55);
      run_transfer("nack_55", 10'h0AA, 1'b1);
   endtask

   task automatic test_timeout();
      logic [9:0] got;
      int t0;
      int n;
      int d0;
      start_send(8'hA5);
      wait_send_state();
      clock_bits(3, got);
      d0 = done_cnt;
      @(negedge clk);
      t0 = cyc;
      ps2_clk_in = 1'b0;
      tick(5);
      ps2_clk_in = 1'b1;
      n = 0;
      while (error !== 1'b1 && n < 400) begin
         n++;
         @(negedge clk);
      end
      checks++;
      if (cyc != t0 + TO + 3) begin
         errors++;
         $display("FAIL timeout_time: error at cycle %0d, expected %0d", cyc, t0 + TO + 3);
      end
      checks++;
      if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0 || send_ready !== 1'b1) begin
         errors++;
         $display("FAIL timeout_release: clk_oe=%b dat_oe=%b ready=%b, expected 0 0 1",
                  ps2_clk_oe, ps2_dat_oe, send_ready);
      end
      tick(2);
      checks++;
      if (done_cnt != d0) begin
         errors++;
         $display("FAIL timeout_done: done pulses %0d, expected 0", done_cnt - d0);
      end
   endtask

   task automatic test_reset_mid();
      logic [9:0] got;
      int d0;
      int e0;
      start_send(8'h3C);
      wait_send_state();
      clock_bits(5, got);
      d0 = done_cnt;
      e0 = err_cnt;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0 || send_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: clk_oe=%b dat_oe=%b ready=%b busy=%b, expected 0 0 1 0",
                  ps2_clk_oe, ps2_dat_oe, send_ready, busy);
      end
      tick(3);
      rst_n = 1'b1;
      tick(5);
      checks++;
      if (done_cnt != d0 || err_cnt != e0) begin
         errors++;
         $display("FAIL reset_mid_pulses: done=%0d error=%0d, expected 0 0", done_cnt - d0, err_cnt - e0);
      end
      start_send(8'hF4);
      run_transfer("after_reset_F4", 10'h10B, 1'b0);
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      send_valid = 1'b1;
      send_data  = 8'h12;
      @(negedge clk);
      send_data  = 8'h34;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL b2b_busy: busy=%b, expected 1", busy);
      end
      run_transfer("b2b_first_12", 10'h0ED, 1'b0);
      @(negedge clk);
      send_valid = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL b2b_second_accept: busy=%b, expected 1", busy);
      end
      run_transfer("b2b_second_34", 10'h1CB, 1'b0);
   endtask

   initial begin
      test_reset();
      test_send_ed();
      test_send_zero();
      test_nack();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      tick(2);
      checks++;
      if (both_cnt != 0) begin
         errors++;
         $display("FAIL done_error_overlap: %0d cycles, expected 0", both_cnt);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 5000, clk cycles PS2 clock is held low before the request (100 us at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 750000, max clk cycles between device clock falling edges (15 ms at 50 MHz).
REQ-003 SHALL have port clk  input  1  system clock; single clock domain, all logic on posedge clk.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port send_valid  input  1  request to transmit send_data.
REQ-006 SHALL have port send_data  input  8  command byte to the device.
REQ-007 SHALL have port send_ready  output  1  high when idle and able to accept a byte.
REQ-008 SHALL have port ps2_clk_in  input  1  raw PS2 clock line, asynchronous.
REQ-009 SHALL have port ps2_dat_in  input  1  raw PS2 data line, asynchronous.
REQ-010 SHALL have port ps2_clk_oe  output  1  1 = drive PS2 clock low, 0 = release (open-drain).
REQ-011 SHALL have port ps2_dat_oe  output  1  1 = drive PS2 data low, 0 = release (open-drain).
REQ-012 SHALL have port busy  output  1  high from byte acceptance until done/error; the receiver uses it to ignore bus activity.
REQ-013 SHALL have port done  output  1  one-cycle pulse when the device acknowledges the byte.
REQ-014 SHALL have port error  output  1  one-cycle pulse on NACK or timeout.

Function
REQ-015 SHALL pass ps2_clk_in and ps2_dat_in each through a 2-FF synchronizer; a falling edge is prev=1 and synced=0, registered on clk.
REQ-016 SHALL have states IDLE, INHIBIT, REQUEST, SEND, ACK, WAIT_IDLE.
REQ-017 IDLE: send_ready=1 and busy=0; handshake send_valid&send_ready latches send_data and odd parity (~^send_data), sets ps2_clk_oe=1, clears counter, next state INHIBIT.
REQ-018 SHALL ignore send_valid while send_ready=0; the latched byte is unaffected by later send_data changes.
REQ-019 INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles, then ps2_dat_oe=1 (start bit) and next state REQUEST.
REQ-020 REQUEST: one cycle with both lines driven low, then ps2_clk_oe=0, bit index=0, timeout counter cleared, next state SEND.
REQ-021 SEND: on each device clock falling edge, drive the next bit: index 0-7 data LSB first (ps2_dat_oe = ~bit), index 8 parity (ps2_dat_oe = ~parity), index 9 stop (ps2_dat_oe=0); index increments (4-bit, no wrap beyond 9).
REQ-022 After the stop bit is placed, SHALL enter ACK; at the next falling edge it samples synced data: 0 -> WAIT_IDLE; 1 -> error pulse, IDLE.
REQ-023 WAIT_IDLE: when synced clock and data are both 1, SHALL pulse done for one cycle and return to IDLE.
REQ-024 Timeout counter SHALL clear on every device falling edge and on each state entry; reaching TIMEOUT_CYCLES in SEND, ACK or WAIT_IDLE -> both oe=0, error pulse, IDLE.
REQ-025 done and error SHALL never assert in the same cycle; busy = ~send_ready.
REQ-026 SHALL release both lines (oe=0) in IDLE, and SHALL release ps2_clk_oe in every state after REQUEST.

Reset
REQ-027 rst_n=0 SHALL immediately (asynchronously) force: state IDLE, ps2_clk_oe=0, ps2_dat_oe=0, send_ready=1, busy=0, done=0, error=0, counters 0.
REQ-028 Reset mid-transfer SHALL abandon the byte with no done/error pulse; the first accepted byte after reset starts a fresh INHIBIT.

Verification
REQ-029 INHIBIT_CYCLES=8, send 0xED, device model clocks and ACKs -> ps2_clk_oe high for 8 cycles; ps2_dat_oe per edge 0,1,0,0,1,0,0,0 (data), 0 (parity=1), 0 (stop); done pulses once.
REQ-030 Send 0x00 -> parity bit 1 (ps2_dat_oe=0 at index 8), eight ps2_dat_oe=1 data bits, done pulses.
REQ-031 Device leaves data high at ACK edge -> error pulses once, done never, IDLE with both oe=0.
REQ-032 TIMEOUT_CYCLES=100, device stops clocking after bit 3 -> error exactly 100 cycles after last falling edge, lines released.
REQ-033 rst_n low during SEND at bit 5 -> oe outputs 0 the same cycle, no done/error; next send 0xF4 completes normally.
REQ-034 send_valid held high with changing send_data while busy -> only the first byte is transmitted; second accepted only after done.
